// File: rtl/ml_pkg.sv
// Shared constants and the packer state encoding for the hard-bit path.
package ml_pkg;

    localparam int unsigned ML_BYTE_W          = 8;
    localparam int unsigned ML_FIFO_DEPTH_DEF  = 4;
    localparam int unsigned ML_FRAME_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,  // no bits held
        S_COLLECT = 2'd1,  // 1..7 bits held
        S_FLUSH   = 2'd2   // partial byte waiting for FIFO space
    } ml_state_t;

endpackage

// File: rtl/ml_byte_fifo.sv
// Synchronous FIFO holding {frame_end, byte}; head is zero while empty.
module ml_byte_fifo
    import ml_pkg::*;
#(
    parameter int unsigned DEPTH = ML_FIFO_DEPTH_DEF,
    parameter int unsigned WIDTH = ML_BYTE_W + 1,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Qualify requests: pop needs data, push needs space (or a same-cycle pop).
    always_comb begin
        do_pop  = i_pop && (count_q != '0);
        do_push = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign o_rdata = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/ml_hardbit_packer.sv
// Packs serial hard bits LSB-first into bytes, tags frame ends, and queues them.
module ml_hardbit_packer
    import ml_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = ML_FIFO_DEPTH_DEF,
    parameter int unsigned FRAME_BYTES = ML_FRAME_BYTES_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_bit_vld,
    input  logic                 i_bit,
    output logic                 o_bit_rdy,
    input  logic                 i_flush,
    output logic [ML_BYTE_W-1:0] o_byte,
    output logic                 o_byte_vld,
    input  logic                 i_byte_rdy,
    output logic                 o_frame_end,
    output logic [15:0]          o_byte_cnt
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BC_W  = $clog2(ML_BYTE_W);
    localparam logic [7:0]  LAST_IDX = 8'(FRAME_BYTES - 1);

    ml_state_t            state_q, state_d;
    logic [BC_W-1:0]      bit_cnt_q;
    logic [ML_BYTE_W-1:0] shreg_q;
    logic [7:0]           frame_idx_q;
    logic [15:0]          byte_cnt_q;

    logic [CNT_W-1:0]     fifo_count;
    logic [ML_BYTE_W:0]   fifo_rdata;
    logic                 fifo_space;
    logic                 accept;
    logic                 byte_done;
    logic                 flush_push;
    logic                 push;
    logic                 push_fe;
    logic [ML_BYTE_W-1:0] merged;
    logic [ML_BYTE_W-1:0] push_byte;
    logic                 pop;

    assign fifo_space = (fifo_count < CNT_W'(FIFO_DEPTH));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a byte completed alongside a flush wins, so no extra pad byte.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (byte_done) begin
                    state_d = S_IDLE;
                end else if (i_flush) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fifo_space) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake, byte assembly and push request.
    always_comb begin
        o_bit_rdy  = (state_q != S_FLUSH) && fifo_space;
        accept     = i_bit_vld && o_bit_rdy;
        merged     = shreg_q | (ML_BYTE_W'(i_bit) << bit_cnt_q);
        byte_done  = accept && (bit_cnt_q == BC_W'(ML_BYTE_W - 1));
        flush_push = (state_q == S_FLUSH) && fifo_space;
        push       = byte_done || flush_push;
        push_byte  = byte_done ? merged : shreg_q;
        push_fe    = flush_push || (frame_idx_q == LAST_IDX);
    end

    // Bit accumulator, frame position and pop counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_idx_q <= '0;
            byte_cnt_q  <= '0;
        end else begin
            if (byte_done || flush_push) begin
                bit_cnt_q <= '0;
                shreg_q   <= '0;
            end else if (accept) begin
                bit_cnt_q <= bit_cnt_q + BC_W'(1);
                shreg_q   <= merged;
            end
            if (push) begin
                frame_idx_q <= push_fe ? '0 : frame_idx_q + 8'd1;
            end
            if (pop) begin
                byte_cnt_q <= byte_cnt_q + 16'd1;
            end
        end
    end

    ml_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ML_BYTE_W + 1),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_wdata ({push_fe, push_byte}),
        .i_pop   (pop),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count)
    );

    assign o_byte_vld  = (fifo_count != '0);
    assign pop         = o_byte_vld && i_byte_rdy;
    assign o_byte      = fifo_rdata[ML_BYTE_W-1:0];
    assign o_frame_end = fifo_rdata[ML_BYTE_W];
    assign o_byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_ml_hardbit_packer.sv
// Randomized and directed bench for ml_hardbit_packer against a queue-based model.
module tb_ml_hardbit_packer;

    localparam int DEPTH = 4;
    localparam int FRAME = 4;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_bit_vld = 1'b0;
    logic        i_bit = 1'b0;
    logic        o_bit_rdy;
    logic        i_flush = 1'b0;
    logic [7:0]  o_byte;
    logic        o_byte_vld;
    logic        i_byte_rdy = 1'b0;
    logic        o_frame_end;
    logic [15:0] o_byte_cnt;

    ml_hardbit_packer #(
        .FIFO_DEPTH  (DEPTH),
        .FRAME_BYTES (FRAME)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_bit_vld   (i_bit_vld),
        .i_bit       (i_bit),
        .o_bit_rdy   (o_bit_rdy),
        .i_flush     (i_flush),
        .o_byte      (o_byte),
        .o_byte_vld  (o_byte_vld),
        .i_byte_rdy  (i_byte_rdy),
        .o_frame_end (o_frame_end),
        .o_byte_cnt  (o_byte_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queued {frame_end, byte}, bits held so far, flush flag.
    logic [8:0] mq[$];
    logic [7:0] m_acc;
    int         m_nb;
    bit         m_fpend;
    int         m_fpos;
    int         m_cnt;
    bit         tx_bits[$];
    logic [8:0] popped[$];
    logic [7:0] sent[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_emit(input logic [7:0] b, input bit forced);
        bit fe;
        fe = forced || (m_fpos == FRAME - 1);
        m_fpos = fe ? 0 : m_fpos + 1;
        mq.push_back({fe, b});
    endfunction

    task automatic step(input bit vld, input bit flush, input bit brdy, input bit rst);
        int sz;
        bit mrdy;
        bit acc;
        bit pop;
        int held;
        i_bit_vld  = vld && (tx_bits.size() > 0);
        i_bit      = (tx_bits.size() > 0) ? tx_bits[0] : 1'b0;
        i_flush    = flush;
        i_byte_rdy = brdy;
        i_reset    = rst;
        @(negedge i_clk);
        sz   = mq.size();
        mrdy = !m_fpend && (sz < DEPTH);
        chk("bit_rdy", o_bit_rdy, mrdy);
        chk("byte_vld", o_byte_vld, sz > 0);
        if (sz > 0) begin
            chk("byte", o_byte, mq[0][7:0]);
            chk("frame_end", o_frame_end, mq[0][8]);
        end
        chk("byte_cnt", o_byte_cnt, m_cnt);
        if (o_byte_vld && brdy && !rst) popped.push_back({o_frame_end, o_byte});
        acc = mrdy && i_bit_vld && !rst;
        pop = (sz > 0) && brdy;
        if (rst) begin
            mq.delete();
            m_acc = '0; m_nb = 0; m_fpend = 0; m_fpos = 0; m_cnt = 0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (acc) begin
                held = m_nb;
                m_acc[m_nb] = i_bit;
                m_nb++;
                if (m_nb == 8) begin
                    m_emit(m_acc, 1'b0);
                    m_acc = '0;
                    m_nb  = 0;
                end else if (flush && held > 0) begin
                    m_fpend = 1;
                end
            end else if (m_fpend) begin
                if (sz < DEPTH) begin
                    m_emit(m_acc, 1'b1);
                    m_acc = '0; m_nb = 0; m_fpend = 0;
                end
            end else if (flush && m_nb > 0) begin
                m_fpend = 1;
            end
            if (acc) void'(tx_bits.pop_front());
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        tx_bits.delete();
        step(0, 0, 0, 1);
        i_reset = 1'b0;
        popped.delete();
        sent.delete();
        #2;
        chk("rst_vld", o_byte_vld, 0);
        chk("rst_byte", o_byte, 0);
        chk("rst_fe", o_frame_end, 0);
        chk("rst_rdy", o_bit_rdy, 1);
        chk("rst_cnt", o_byte_cnt, 0);
    endtask

    task automatic queue_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) tx_bits.push_back(b[i]);
    endtask

    task automatic run_tx(input bit brdy);
        int guard = 0;
        while (tx_bits.size() > 0 && guard < 100) begin
            step(1, 0, brdy, 0);
            guard++;
        end
        chk("tx_timeout", tx_bits.size(), 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (mq.size() > 0 && guard < 64) begin
            step(0, 0, 1, 0);
            guard++;
        end
        step(0, 0, 1, 0);
        chk("drain_vld", o_byte_vld, 0);
    endtask

    initial begin
        logic [7:0] b;

        // Reset state.
        do_reset();

        // 1,0,1,0,1,0,0,1 -> 0x95, visible one cycle after the 8th bit.
        queue_bits(8'h95, 8);
        run_tx(0);
        chk("d95_vld", o_byte_vld, 1);
        chk("d95_byte", o_byte, 8'h95);
        chk("d95_fe", o_frame_end, 0);
        drain();

        // Backpressure: 5 bytes offered, only 4 fit, the rest stalls losslessly.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            queue_bits(b, 8);
        end
        for (int i = 0; i < 45; i++) step(1, 0, 0, 0);
        chk("stall_rdy", o_bit_rdy, 0);
        chk("stall_left", tx_bits.size(), 8);
        run_tx(1);
        drain();
        chk("bp_count", popped.size(), 5);
        for (int i = 0; i < 5 && i < popped.size(); i++) chk("bp_byte", popped[i][7:0], sent[i]);

        // 1,1,0 then flush -> 0x03 frame end; next four bytes form a fresh frame.
        do_reset();
        queue_bits(8'h03, 3);
        run_tx(0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("fl_byte", o_byte, 8'h03);
        chk("fl_fe", o_frame_end, 1);
        queue_bits(8'h11, 8); queue_bits(8'h22, 8); queue_bits(8'h33, 8); queue_bits(8'h44, 8);
        run_tx(1);
        drain();
        chk("fl_n", popped.size(), 5);
        if (popped.size() == 5) begin
            chk("fl_p0", popped[0], 9'h103);
            chk("fl_p1", popped[1], 9'h011);
            chk("fl_p3", popped[3], 9'h033);
            chk("fl_p4", popped[4], 9'h144);
        end
        chk("fl_cnt", o_byte_cnt, 5);

        // Four full bytes: frame end only on the fourth, count 4.
        do_reset();
        for (int i = 1; i <= 4; i++) queue_bits(8'(i), 8);
        run_tx(1);
        drain();
        chk("fr_n", popped.size(), 4);
        if (popped.size() == 4) begin
            chk("fr_p0", popped[0], 9'h001);
            chk("fr_p2", popped[2], 9'h003);
            chk("fr_p3", popped[3], 9'h104);
        end
        chk("fr_cnt", o_byte_cnt, 4);

        // Reset mid-byte discards the partial bits.
        do_reset();
        queue_bits(8'h1F, 5);
        run_tx(0);
        do_reset();
        queue_bits(8'hA5, 8);
        run_tx(1);
        drain();
        chk("mr_n", popped.size(), 1);
        if (popped.size() == 1) chk("mr_p0", popped[0], 9'h0A5);
        chk("mr_cnt", o_byte_cnt, 1);

        // Flush together with the 8th bit: a single 0xFF, back to idle.
        do_reset();
        queue_bits(8'hFF, 7);
        run_tx(0);
        queue_bits(8'h01, 1);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("ff_rdy", o_bit_rdy, 1);
        drain();
        chk("ff_n", popped.size(), 1);
        if (popped.size() == 1) chk("ff_p0", popped[0], 9'h0FF);

        // Random traffic with occasional flushes and resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (tx_bits.size() < 4) tx_bits.push_back(1'($urandom));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 499) == 0);
        end
        i_reset = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
